// File: rtl/acc_pkg.sv
// Shared widths, error-cause indices and the output saturation helper for
// the banked adder-tree accumulator.
package acc_pkg;

  // Bit positions in the per-beat error-cause vector.
  localparam int ERR_SOP_OPEN    = 0;  // sop arrived while the bank had an open packet
  localparam int ERR_BEAT_CLOSED = 1;  // non-sop beat arrived on a closed bank
  localparam int ERR_CAUSES      = 2;

  typedef struct packed {
    logic               sat;
    logic signed [63:0] val;
  } sat_res_t;

  // Number of registered adder levels; a single lane needs none.
  function automatic int tree_levels(input int cpf);
    return (cpf <= 1) ? 0 : $clog2(cpf);
  endfunction

  function automatic int tree_w(input int m_dw, input int cpf);
    return m_dw + tree_levels(cpf);
  endfunction

  function automatic int sel_w(input int num_acc);
    return (num_acc <= 1) ? 1 : $clog2(num_acc);
  endfunction

  // Clamp a signed value (at most 64 bits wide) into out_w signed bits.
  function automatic sat_res_t sat_trunc(input logic signed [63:0] value,
                                         input int unsigned out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_res_t r;
    r.sat = 1'b0;
    r.val = value;
    if (out_w < 64) begin
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (value > hi) begin
        r.val = hi;
        r.sat = 1'b1;
      end else if (value < lo) begin
        r.val = lo;
        r.sat = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/acc_tree_pipe.sv
// Pipelined binary adder tree over CPF signed lanes (zero-padded to a power
// of two) with a matching sideband delay line for vld/sop/eop/sel.
module acc_tree_pipe
  import acc_pkg::*;
#(
  parameter int CPF   = 4,
  parameter int M_DW  = 32,
  parameter int SEL_W = 1,
  localparam int TL   = tree_levels(CPF),
  localparam int T_W  = tree_w(M_DW, CPF)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CPF*M_DW-1:0]   mul,
  input  logic                  in_vld,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic [SEL_W-1:0]      in_sel,
  output logic signed [T_W-1:0] t,
  output logic                  t_vld,
  output logic                  t_sop,
  output logic                  t_eop,
  output logic [SEL_W-1:0]      t_sel
);

  localparam int NP   = 1 << TL;
  localparam int SB_W = SEL_W + 3;

  if (TL == 0) begin : g_flat
    assign t     = T_W'($signed(mul[M_DW-1:0]));
    assign t_vld = in_vld;
    assign t_sop = in_sop;
    assign t_eop = in_eop;
    assign t_sel = in_sel;
  end else begin : g_tree
    // Heap-ordered tree: node 0 is the root, leaves follow the NP-1 adders.
    // Every node is carried at the full T_W width; the headroom above each
    // level's natural width is pure sign extension, so results are identical
    // to a per-level growing datapath.
    logic signed [T_W-1:0] node  [NP-1];
    logic signed [T_W-1:0] all_n [2*NP-1];
    logic [SB_W-1:0]       sb    [TL];

    // Assemble adder outputs and sign-extended (or zero-padded) input lanes.
    always_comb begin
      for (int unsigned k = 0; k < NP - 1; k++) all_n[k] = node[k];
      for (int unsigned k = 0; k < NP; k++) all_n[NP-1+k] = '0;
      for (int unsigned k = 0; k < CPF; k++)
        all_n[NP-1+k] = T_W'($signed(mul[k*M_DW +: M_DW]));
    end

    // One registered 2-input add per node; no enable, no reset on data.
    always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NP - 1; i++)
        node[i] <= all_n[2*i+1] + all_n[2*i+2];
    end

    // Sideband travels TL stages alongside the data; reset drops in-flight beats.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < TL; i++) sb[i] <= '0;
      end else begin
        sb[0] <= {in_vld, in_sop, in_eop, in_sel};
        for (int unsigned i = 1; i < TL; i++) sb[i] <= sb[i-1];
      end
    end

    assign t = node[0];
    assign {t_vld, t_sop, t_eop, t_sel} = sb[TL-1];
  end

endmodule

// File: rtl/acc_tree_bank.sv
// Banked adder-tree accumulator: sums CPF products per beat, accumulates per
// bank across a sop..eop packet and emits a framed result strobe.
// Optional: define ACC_TREE_BANK_SAT_EN to clamp the result into OUT_W bits
// (sat_o flags clamping); otherwise the result wraps and sat_o stays 0.
module acc_tree_bank
  import acc_pkg::*;
#(
  parameter int CPF       = 4,
  parameter int M_DW      = 32,
  parameter int ACC_WIDTH = 40,
  parameter int OUT_W     = 32,
  parameter int NUM_ACC   = 1,
  localparam int SEL_W    = sel_w(NUM_ACC),
  localparam int T_W      = tree_w(M_DW, CPF)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CPF*M_DW-1:0] mul,
  input  logic                in_vld,
  input  logic                in_sop,
  input  logic                in_eop,
  input  logic [SEL_W-1:0]    in_sel,
  output logic [OUT_W-1:0]    a_o,
  output logic                a_vld,
  output logic [SEL_W-1:0]    a_sel,
  output logic                sat_o,
  output logic                err_o
);

  logic signed [T_W-1:0]       t;
  logic                        t_vld;
  logic                        t_sop;
  logic                        t_eop;
  logic [SEL_W-1:0]            t_sel;
  logic [SEL_W-1:0]            bank;
  logic                        bank_ok;
  logic                        cur_open;
  logic signed [ACC_WIDTH-1:0] acc_q [NUM_ACC];
  logic [NUM_ACC-1:0]          open_q;
  logic signed [ACC_WIDTH-1:0] acc_cur;
  logic signed [ACC_WIDTH-1:0] t_ext;
  logic signed [ACC_WIDTH-1:0] sum;
  logic [ERR_CAUSES-1:0]       err_hit;
  logic [OUT_W-1:0]            res;
  logic                        res_sat;
  logic                        fire;
`ifdef ACC_TREE_BANK_SAT_EN
  sat_res_t                    sr;
`endif

  acc_tree_pipe #(
    .CPF  (CPF),
    .M_DW (M_DW),
    .SEL_W(SEL_W)
  ) u_tree (
    .clk   (clk),
    .rst   (rst),
    .mul   (mul),
    .in_vld(in_vld),
    .in_sop(in_sop),
    .in_eop(in_eop),
    .in_sel(in_sel),
    .t     (t),
    .t_vld (t_vld),
    .t_sop (t_sop),
    .t_eop (t_eop),
    .t_sel (t_sel)
  );

  // Bank select, running sum, protocol checks and output formatting.
  always_comb begin
    bank     = (NUM_ACC == 1) ? '0 : t_sel;
    // Selects beyond NUM_ACC (non-power-of-two bank counts) are dropped.
    bank_ok  = (32'(bank) < NUM_ACC);
    cur_open = bank_ok ? open_q[bank] : 1'b0;
    acc_cur  = bank_ok ? acc_q[bank] : '0;
    t_ext    = ACC_WIDTH'(t);
    sum      = t_sop ? t_ext : acc_cur + t_ext;
    fire     = t_vld & t_eop & bank_ok;
    err_hit                  = '0;
    err_hit[ERR_SOP_OPEN]    = t_vld & bank_ok &  t_sop &  cur_open;
    err_hit[ERR_BEAT_CLOSED] = t_vld & bank_ok & ~t_sop & ~cur_open;
`ifdef ACC_TREE_BANK_SAT_EN
    sr      = sat_trunc(64'(sum), OUT_W);
    res     = sr.val[OUT_W-1:0];
    res_sat = sr.sat;
`else
    res     = sum[OUT_W-1:0];
    res_sat = 1'b0;
`endif
  end

  // Per-bank accumulators, packet-open flags and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned b = 0; b < NUM_ACC; b++) acc_q[b] <= '0;
      open_q <= '0;
      err_o  <= 1'b0;
    end else begin
      if (t_vld && bank_ok) begin
        acc_q[bank]  <= sum;
        open_q[bank] <= ~t_eop;
      end
      err_o <= err_o | (|err_hit);
    end
  end

  // Result register: strobe for one cycle, hold data between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_o   <= '0;
      a_vld <= 1'b0;
      a_sel <= '0;
      sat_o <= 1'b0;
    end else begin
      a_vld <= fire;
      if (fire) begin
        a_o   <= res;
        a_sel <= bank;
        sat_o <= res_sat;
      end
    end
  end

endmodule
